decode_stage: RTL and testbench

Instruction-decode stage of the 64-bit LEGv8 pipeline, directly upstream of the execution stage. It holds the 32×64 register file, decodes each 32-bit instruction into the execution-stage control bundle, reads operands, and sign-extends immediates. Results are registered into the ID/EX pipeline register that drives the execution stage inputs. It also detects load-use hazards, stalls fetch, and inserts bubbles on hazards, flushes and illegal opcodes.

---
 rtl/decode_stage.sv | 176 +++++++++++++++++
 tb/tb_decode_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction-decode stage for the 64-bit LEGv8 pipeline: register file, control decode,
// immediate extension, load-use hazard detection and the ID/EX pipeline register.
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [63:0] if_addr,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_reg,
    input  logic [63:0] wb_data,
    output logic        stall,
    output logic        illegal,
    output logic        ex_valid,
    output logic [31:0] ex_instr,
    output logic [63:0] ex_addr,
    output logic [63:0] ex_signext,
    output logic [63:0] ex_data1,
    output logic [63:0] ex_data2,
    output logic [1:0]  ex_alusrc,
    output logic [1:0]  ex_aluop,
    output logic        ex_b,
    output logic        ex_bz,
    output logic        ex_bnz,
    output logic        ex_memwrite,
    output logic        ex_memread,
    output logic        ex_memtoreg,
    output logic        ex_regwrite
);
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [63:0] addr;
        logic [63:0] signext;
        logic [63:0] data1;
        logic [63:0] data2;
        logic [1:0]  alusrc;
        logic [1:0]  aluop;
        logic        b;
        logic        bz;
        logic        bnz;
        logic        memwrite;
        logic        memread;
        logic        memtoreg;
        logic        regwrite;
    } idex_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;

    logic [63:0] rf_q [32];
    idex_t       idex_q, idex_d, ctl;
    logic        illegal_q, illegal_d;
    logic        legal, use1, use2, reg2_lo, hazard;
    logic [4:0]  r1, r2, ld_rd;
    logic [63:0] rdata1, rdata2;

    always_comb begin
        ctl     = '0;
        legal   = 1'b0;
        use1    = 1'b0;
        use2    = 1'b0;
        reg2_lo = 1'b0;
        if (if_instr[31:21] == OP_ADD || if_instr[31:21] == OP_SUB ||
            if_instr[31:21] == OP_AND || if_instr[31:21] == OP_ORR) begin
            legal        = 1'b1;
            use1         = 1'b1;
            use2         = 1'b1;
            ctl.aluop    = 2'b10;
            ctl.regwrite = 1'b1;
        end else if (if_instr[31:21] == OP_LDUR) begin
            legal        = 1'b1;
            use1         = 1'b1;
            ctl.alusrc   = 2'b01;
            ctl.memread  = 1'b1;
            ctl.memtoreg = 1'b1;
            ctl.regwrite = 1'b1;
            ctl.signext  = {{55{if_instr[20]}}, if_instr[20:12]};
        end else if (if_instr[31:21] == OP_STUR) begin
            legal        = 1'b1;
            use1         = 1'b1;
            use2         = 1'b1;
            reg2_lo      = 1'b1;
            ctl.alusrc   = 2'b01;
            ctl.memwrite = 1'b1;
            ctl.signext  = {{55{if_instr[20]}}, if_instr[20:12]};
        end else if (if_instr[31:22] == OP_ADDI || if_instr[31:22] == OP_SUBI) begin
            legal        = 1'b1;
            use1         = 1'b1;
            ctl.alusrc   = 2'b10;
            ctl.aluop    = 2'b10;
            ctl.regwrite = 1'b1;
            ctl.signext  = {52'd0, if_instr[21:10]};
        end else if (if_instr[31:24] == OP_CBZ || if_instr[31:24] == OP_CBNZ) begin
            // CB tests only Rt; [9:5] belongs to the offset, so it is not a hazard source
            legal        = 1'b1;
            use2         = 1'b1;
            reg2_lo      = 1'b1;
            ctl.aluop    = 2'b01;
            ctl.bz       = ~if_instr[24];
            ctl.bnz      = if_instr[24];
            ctl.signext  = {{45{if_instr[23]}}, if_instr[23:5]};
        end else if (if_instr[31:26] == OP_B) begin
            legal        = 1'b1;
            ctl.aluop    = 2'b01;
            ctl.b        = 1'b1;
            ctl.signext  = {{38{if_instr[25]}}, if_instr[25:0]};
        end
    end

    assign r1     = if_instr[9:5];
    assign r2     = reg2_lo ? if_instr[4:0] : if_instr[20:16];
    assign rdata1 = (r1 == 5'd31) ? '0 : (wb_en && wb_reg == r1) ? wb_data : rf_q[r1];
    assign rdata2 = (r2 == 5'd31) ? '0 : (wb_en && wb_reg == r2) ? wb_data : rf_q[r2];

    assign ld_rd  = idex_q.instr[4:0];
    assign hazard = if_valid && idex_q.valid && idex_q.memread && ld_rd != 5'd31 &&
                    ((use1 && r1 == ld_rd) || (use2 && r2 == ld_rd));
    assign stall  = hazard && !flush && !rst;

    always_comb begin
        idex_d    = '0;
        illegal_d = 1'b0;
        if (flush || !if_valid || hazard) begin
            idex_d = '0;
        end else if (!legal) begin
            illegal_d = 1'b1;
        end else begin
            idex_d       = ctl;
            idex_d.valid = 1'b1;
            idex_d.instr = if_instr;
            idex_d.addr  = if_addr;
            idex_d.data1 = rdata1;
            idex_d.data2 = rdata2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
            idex_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (wb_en && wb_reg != 5'd31) rf_q[wb_reg] <= wb_data;
            idex_q    <= idex_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal     = illegal_q;
    assign ex_valid    = idex_q.valid;
    assign ex_instr    = idex_q.instr;
    assign ex_addr     = idex_q.addr;
    assign ex_signext  = idex_q.signext;
    assign ex_data1    = idex_q.data1;
    assign ex_data2    = idex_q.data2;
    assign ex_alusrc   = idex_q.alusrc;
    assign ex_aluop    = idex_q.aluop;
    assign ex_b        = idex_q.b;
    assign ex_bz       = idex_q.bz;
    assign ex_bnz      = idex_q.bnz;
    assign ex_memwrite = idex_q.memwrite;
    assign ex_memread  = idex_q.memread;
    assign ex_memtoreg = idex_q.memtoreg;
    assign ex_regwrite = idex_q.regwrite;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected ID/EX bundles are queued as each step is
// driven and popped for comparison after the following rising edge.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst, if_valid, flush, wb_en;
    logic [31:0] if_instr;
    logic [63:0] if_addr, wb_data;
    logic [4:0]  wb_reg;
    logic        stall, illegal, ex_valid;
    logic [31:0] ex_instr;
    logic [63:0] ex_addr, ex_signext, ex_data1, ex_data2;
    logic [1:0]  ex_alusrc, ex_aluop;
    logic        ex_b, ex_bz, ex_bnz, ex_memwrite, ex_memread, ex_memtoreg, ex_regwrite;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_addr(if_addr),
        .flush(flush), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .stall(stall), .illegal(illegal), .ex_valid(ex_valid), .ex_instr(ex_instr),
        .ex_addr(ex_addr), .ex_signext(ex_signext), .ex_data1(ex_data1), .ex_data2(ex_data2),
        .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .ex_b(ex_b), .ex_bz(ex_bz), .ex_bnz(ex_bnz),
        .ex_memwrite(ex_memwrite), .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite)
    );

    // ctl = {b, bz, bnz, memwrite, memread, memtoreg, regwrite}
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [63:0] addr;
        logic [63:0] sext;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [1:0]  alusrc;
        logic [1:0]  aluop;
        logic [6:0]  ctl;
        logic        ill;
    } exp_t;

    localparam logic [31:0] ADD3    = 32'h8B02_0023; // ADD X3,X1,X2
    localparam logic [31:0] ADD54   = 32'h8B02_0085; // ADD X5,X4,X2
    localparam logic [31:0] ADD5_31 = 32'h8B02_03E5; // ADD X5,X31,X2
    localparam logic [31:0] SUB7    = 32'hCB06_00C7; // SUB X7,X6,X6
    localparam logic [31:0] LD4     = 32'hF85F_8024; // LDUR X4,[X1,#-8]
    localparam logic [31:0] STUR2   = 32'hF800_8022; // STUR X2,[X1,#8]
    localparam logic [31:0] ADDI8   = 32'h913F_FC28; // ADDI X8,X1,#0xFFF
    localparam logic [31:0] CBNZ9   = 32'hB5FF_FFE9; // CBNZ X9,#-1
    localparam logic [31:0] BNEG2   = 32'h17FF_FFFE; // B #-2
    localparam logic [6:0]  C_R     = 7'b0000001;
    localparam logic [6:0]  C_LD    = 7'b0000111;
    localparam logic [6:0]  C_ST    = 7'b0001000;
    localparam logic [6:0]  C_CBNZ  = 7'b0010000;
    localparam logic [6:0]  C_B     = 7'b1000000;
    localparam logic [63:0] LD_SEXT = 64'hFFFF_FFFF_FFFF_FFF8;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [63:0] pc       = 64'h400;

    function automatic exp_t mk(input logic v, input logic [31:0] ins, input logic [63:0] sx,
                                input logic [63:0] a, input logic [63:0] b, input logic [1:0] src,
                                input logic [1:0] op, input logic [6:0] c, input logic il);
        exp_t e;
        e.valid = v;  e.instr = ins; e.addr = '0;  e.sext = sx; e.d1 = a; e.d2 = b;
        e.alusrc = src; e.aluop = op; e.ctl = c; e.ill = il;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [31:0] ins, input logic fl,
                        input logic we, input logic [4:0] wr, input logic [63:0] wd,
                        input logic r, input logic exp_stall, input exp_t e);
        exp_t got;
        rst = r; if_valid = v; if_instr = ins; if_addr = pc; flush = fl;
        wb_en = we; wb_reg = wr; wb_data = wd;
        if (e.valid) e.addr = pc;
        sb.push_back(e);
        #1;
        chk({tag, ".stall"}, {63'd0, stall}, {63'd0, exp_stall});
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, ".valid"},   {63'd0, ex_valid},   {63'd0, got.valid});
        chk({tag, ".instr"},   {32'd0, ex_instr},   {32'd0, got.instr});
        chk({tag, ".addr"},    ex_addr,             got.addr);
        chk({tag, ".signext"}, ex_signext,          got.sext);
        chk({tag, ".data1"},   ex_data1,            got.d1);
        chk({tag, ".data2"},   ex_data2,            got.d2);
        chk({tag, ".alu"},     {60'd0, ex_alusrc, ex_aluop}, {60'd0, got.alusrc, got.aluop});
        chk({tag, ".ctl"},     {57'd0, ex_b, ex_bz, ex_bnz, ex_memwrite, ex_memread,
                                ex_memtoreg, ex_regwrite}, {57'd0, got.ctl});
        chk({tag, ".illegal"}, {63'd0, illegal},    {63'd0, got.ill});
        pc = pc + 64'd4;
        @(negedge clk);
    endtask

    initial begin
        exp_t bub, ld;
        bub = mk(0, '0, '0, '0, '0, 2'b00, 2'b00, '0, 1'b0);
        ld  = mk(1, LD4, LD_SEXT, 64'd5, 64'd0, 2'b01, 2'b00, C_LD, 1'b0);
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_addr = '0; flush = 1'b0;
        wb_en = 1'b0; wb_reg = '0; wb_data = '0;
        @(negedge clk);

        step("reset",     0, '0,      0, 0, 5'd0,  '0,          1, 0, bub);
        step("wr_x1",     0, '0,      0, 1, 5'd1,  64'd5,       0, 0, bub);
        step("wr_x2",     0, '0,      0, 1, 5'd2,  64'd7,       0, 0, bub);
        step("add",       1, ADD3,    0, 0, 5'd0,  '0,          0, 0,
             mk(1, ADD3, '0, 64'd5, 64'd7, 2'b00, 2'b10, C_R, 0));
        step("ldur",      1, LD4,     0, 0, 5'd0,  '0,          0, 0, ld);
        step("lu_stall",  1, ADD54,   0, 0, 5'd0,  '0,          0, 1, bub);
        step("lu_issue",  1, ADD54,   0, 1, 5'd4,  64'h1234,    0, 0,
             mk(1, ADD54, '0, 64'h1234, 64'd7, 2'b00, 2'b10, C_R, 0));
        step("ldur2",     1, LD4,     0, 0, 5'd0,  '0,          0, 0, ld);
        step("x31_src",   1, ADD5_31, 0, 0, 5'd0,  '0,          0, 0,
             mk(1, ADD5_31, '0, 64'd0, 64'd7, 2'b00, 2'b10, C_R, 0));
        step("bypass",    1, SUB7,    0, 1, 5'd6,  64'hABCD,    0, 0,
             mk(1, SUB7, '0, 64'hABCD, 64'hABCD, 2'b00, 2'b10, C_R, 0));
        step("wr_x31",    1, ADD5_31, 0, 1, 5'd31, 64'hDEAD,    0, 0,
             mk(1, ADD5_31, '0, 64'd0, 64'd7, 2'b00, 2'b10, C_R, 0));
        step("rd_x31",    1, ADD5_31, 0, 0, 5'd0,  '0,          0, 0,
             mk(1, ADD5_31, '0, 64'd0, 64'd7, 2'b00, 2'b10, C_R, 0));
        step("rf_x6",     1, SUB7,    0, 1, 5'd9,  64'h99,      0, 0,
             mk(1, SUB7, '0, 64'hABCD, 64'hABCD, 2'b00, 2'b10, C_R, 0));
        step("cbnz",      1, CBNZ9,   0, 0, 5'd0,  '0,          0, 0,
             mk(1, CBNZ9, '1, 64'd0, 64'h99, 2'b00, 2'b01, C_CBNZ, 0));
        step("illegal",   1, 32'h0,   0, 0, 5'd0,  '0,          0, 0,
             mk(0, '0, '0, '0, '0, 2'b00, 2'b00, '0, 1'b1));
        step("addi",      1, ADDI8,   0, 0, 5'd0,  '0,          0, 0,
             mk(1, ADDI8, 64'hFFF, 64'd5, 64'd0, 2'b10, 2'b10, C_R, 0));
        step("stur",      1, STUR2,   0, 0, 5'd0,  '0,          0, 0,
             mk(1, STUR2, 64'd8, 64'd5, 64'd7, 2'b01, 2'b00, C_ST, 0));
        step("b",         1, BNEG2,   0, 0, 5'd0,  '0,          0, 0,
             mk(1, BNEG2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'd0, 2'b00, 2'b01, C_B, 0));
        step("ill_flush", 1, 32'h0,   1, 0, 5'd0,  '0,          0, 0, bub);
        step("ldur3",     1, LD4,     0, 0, 5'd0,  '0,          0, 0, ld);
        step("flush_haz", 1, ADD54,   1, 0, 5'd0,  '0,          0, 0, bub);
        step("ldur4",     1, LD4,     0, 0, 5'd0,  '0,          0, 0, ld);
        step("lu_stall2", 1, ADD54,   0, 0, 5'd0,  '0,          0, 1, bub);
        step("ldur5",     1, LD4,     0, 0, 5'd0,  '0,          0, 0, ld);
        step("rst_stall", 1, ADD54,   0, 0, 5'd0,  '0,          1, 0, bub);
        step("post_rst",  1, ADD3,    0, 0, 5'd0,  '0,          0, 0,
             mk(1, ADD3, '0, 64'd0, 64'd0, 2'b00, 2'b10, C_R, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
